// File: rtl/chiptester_pkg.sv
// Shared widths, word field offsets and FSM encoding for the chip-tester result checker.
package chiptester_pkg;

  localparam int RTF_WIDTH   = 24;
  localparam int CYCLE_RANGE = 5;
  localparam int IDX_WIDTH   = 16;

  localparam int RF_WIDTH = RTF_WIDTH + CYCLE_RANGE + 1;
  localparam int EF_WIDTH = 2 * RTF_WIDTH + CYCLE_RANGE;
  localparam int LF_WIDTH = IDX_WIDTH + RTF_WIDTH + CYCLE_RANGE + 1;

  // RES_FIFO word {result, cycle, timeout}
  localparam int RF_TO_BIT  = 0;
  localparam int RF_CYC_LSB = 1;
  localparam int RF_RES_LSB = 1 + CYCLE_RANGE;

  // EXP_FIFO word {mask, expected, exp_cycle}
  localparam int EF_CYC_LSB  = 0;
  localparam int EF_EXP_LSB  = CYCLE_RANGE;
  localparam int EF_MASK_LSB = CYCLE_RANGE + RTF_WIDTH;

  // LOG_FIFO word {index, result, cycle, timeout}: the low bits are a RES_FIFO word verbatim
  localparam int LF_IDX_LSB = RF_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_COMPARE = 3'd2,
    ST_LOG     = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/dut_result_cmp.sv
// Result-vs-expected compare. Operands are the legacy FIFO q registers, stable from the cycle
// after the read until the next read. Define RESCHK_CYCLE_CMP_EN to also check trigger latency.
module dut_result_cmp
  import chiptester_pkg::*;
(
  input  logic [RF_WIDTH-1:0] rf_word_i,
  input  logic [EF_WIDTH-1:0] ef_word_i,
  output logic                fail_o
);

  logic [RTF_WIDTH-1:0]   result;
  logic [RTF_WIDTH-1:0]   expected;
  logic [RTF_WIDTH-1:0]   mask;
  logic [CYCLE_RANGE-1:0] cycle;
  logic [CYCLE_RANGE-1:0] exp_cycle;
  logic                   timeout;
  logic                   data_fail;

  assign result    = rf_word_i[RF_RES_LSB +: RTF_WIDTH];
  assign cycle     = rf_word_i[RF_CYC_LSB +: CYCLE_RANGE];
  assign timeout   = rf_word_i[RF_TO_BIT];
  assign expected  = ef_word_i[EF_EXP_LSB +: RTF_WIDTH];
  assign mask      = ef_word_i[EF_MASK_LSB +: RTF_WIDTH];
  assign exp_cycle = ef_word_i[EF_CYC_LSB +: CYCLE_RANGE];

  assign data_fail = (|((result ^ expected) & mask)) | timeout;

`ifdef RESCHK_CYCLE_CMP_EN
  assign fail_o = data_fail | (cycle != exp_cycle);
`else
  // Cycle fields are carried but deliberately ignored in this build.
  logic [2*CYCLE_RANGE-1:0] unused_cycles;
  assign unused_cycles = {cycle, exp_cycle};
  assign fail_o        = data_fail;
`endif

endmodule

// File: rtl/dut_result_checker.sv
// Pairs RES_FIFO results with EXP_FIFO expectations, counts pass/fail and logs failures.
// Optional RESCHK_CYCLE_CMP_EN adds a cycle-latency compare inside dut_result_cmp.
module dut_result_checker
  import chiptester_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [IDX_WIDTH-1:0] num_vectors,
  input  logic [RF_WIDTH-1:0]  rfifo_data,
  output logic                 rfifo_rdreq,
  input  logic                 rfifo_rdempty,
  input  logic [EF_WIDTH-1:0]  efifo_data,
  output logic                 efifo_rdreq,
  input  logic                 efifo_rdempty,
  output logic [LF_WIDTH-1:0]  lfifo_data,
  output logic                 lfifo_wrreq,
  input  logic                 lfifo_wrfull,
  output logic                 busy,
  output logic                 done,
  output logic [IDX_WIDTH-1:0] pass_count,
  output logic [IDX_WIDTH-1:0] fail_count
);

  state_e               state_q, state_d;
  logic [IDX_WIDTH-1:0] index_q, index_d;
  logic [IDX_WIDTH-1:0] n_q, n_d;
  logic [IDX_WIDTH-1:0] pass_q, pass_d;
  logic [IDX_WIDTH-1:0] fail_q, fail_d;
  logic [LF_WIDTH-1:0]  log_data_q, log_data_d;
  logic                 log_wr_q, log_wr_d;
  logic                 rd_en;
  logic                 vec_fail;

  dut_result_cmp u_cmp (
    .rf_word_i (rfifo_data),
    .ef_word_i (efifo_data),
    .fail_o    (vec_fail)
  );

  function automatic logic [IDX_WIDTH-1:0] sat_inc(input logic [IDX_WIDTH-1:0] v);
    return (v == '1) ? v : v + IDX_WIDTH'(1);
  endfunction

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    n_d        = n_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    log_data_d = log_data_q;
    log_wr_d   = 1'b0;
    rd_en      = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_FETCH;
          index_d = '0;
          pass_d  = '0;
          fail_d  = '0;
          n_d     = num_vectors;
        end
      end
      ST_FETCH: begin
        if (index_q == n_q) begin
          state_d = ST_DONE;
        end else if (!rfifo_rdempty && !efifo_rdempty) begin
          rd_en   = 1'b1;
          state_d = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        if (vec_fail) begin
          fail_d  = sat_inc(fail_q);
          state_d = ST_LOG;
        end else begin
          pass_d  = sat_inc(pass_q);
          index_d = index_q + IDX_WIDTH'(1);
          state_d = ST_FETCH;
        end
      end
      ST_LOG: begin
        // RES_FIFO q still holds the failing word: no read has been issued since.
        if (!lfifo_wrfull) begin
          log_wr_d   = 1'b1;
          log_data_d = {index_q, rfifo_data};
          index_d    = index_q + IDX_WIDTH'(1);
          state_d    = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      index_q    <= '0;
      n_q        <= '0;
      pass_q     <= '0;
      fail_q     <= '0;
      log_data_q <= '0;
      log_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      n_q        <= n_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      log_data_q <= log_data_d;
      log_wr_q   <= log_wr_d;
    end
  end

  assign rfifo_rdreq = rd_en;
  assign efifo_rdreq = rd_en;
  assign lfifo_data  = log_data_q;
  assign lfifo_wrreq = log_wr_q;
  assign busy        = (state_q == ST_FETCH) || (state_q == ST_COMPARE) || (state_q == ST_LOG);
  assign done        = (state_q == ST_DONE);
  assign pass_count  = pass_q;
  assign fail_count  = fail_q;

endmodule

// File: tb/tb_dut_result_checker.sv
// Scoreboard bench for dut_result_checker: legacy FIFO models, expected log queue and monitor.
module tb_dut_result_checker;
  import chiptester_pkg::*;

  logic                 clock = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 start = 1'b0;
  logic [IDX_WIDTH-1:0] num_vectors = '0;
  logic [RF_WIDTH-1:0]  rfifo_data = '0;
  logic                 rfifo_rdreq;
  logic                 rfifo_rdempty;
  logic [EF_WIDTH-1:0]  efifo_data = '0;
  logic                 efifo_rdreq;
  logic                 efifo_rdempty;
  logic [LF_WIDTH-1:0]  lfifo_data;
  logic                 lfifo_wrreq;
  logic                 lfifo_wrfull = 1'b0;
  logic                 busy;
  logic                 done;
  logic [IDX_WIDTH-1:0] pass_count;
  logic [IDX_WIDTH-1:0] fail_count;

  int n_checks = 0;
  int n_errors = 0;
  int rd_count = 0;
  int wr_count = 0;

  logic [RF_WIDTH-1:0] res_mem [64];
  logic [EF_WIDTH-1:0] exp_mem [64];
  int res_wr = 0, res_rd = 0, exp_wr = 0, exp_rd = 0;
  logic [LF_WIDTH-1:0] exp_log [$];

  always #5 clock = ~clock;

  dut_result_checker dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .num_vectors   (num_vectors),
    .rfifo_data    (rfifo_data),
    .rfifo_rdreq   (rfifo_rdreq),
    .rfifo_rdempty (rfifo_rdempty),
    .efifo_data    (efifo_data),
    .efifo_rdreq   (efifo_rdreq),
    .efifo_rdempty (efifo_rdempty),
    .lfifo_data    (lfifo_data),
    .lfifo_wrreq   (lfifo_wrreq),
    .lfifo_wrfull  (lfifo_wrfull),
    .busy          (busy),
    .done          (done),
    .pass_count    (pass_count),
    .fail_count    (fail_count)
  );

  // Legacy (non-show-ahead) FIFOs: q updates on the edge that accepts rdreq.
  assign rfifo_rdempty = (res_wr == res_rd);
  assign efifo_rdempty = (exp_wr == exp_rd);

  always @(posedge clock) begin
    if (rfifo_rdreq && (res_rd != res_wr)) begin
      rfifo_data <= res_mem[res_rd % 64];
      res_rd     <= res_rd + 1;
    end
    if (efifo_rdreq && (exp_rd != exp_wr)) begin
      efifo_data <= exp_mem[exp_rd % 64];
      exp_rd     <= exp_rd + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: read-side protocol and log-write scoreboard.
  always @(negedge clock) begin
    #1;
    if (reset_n) begin
      if (rfifo_rdreq || efifo_rdreq) begin
        rd_count++;
        check("rdreq_pair", 64'(rfifo_rdreq), 64'(efifo_rdreq));
        check("rd_while_empty", 64'(rfifo_rdempty | efifo_rdempty), 64'd0);
      end
      if (lfifo_wrreq) begin
        wr_count++;
        check("log_write_expected", 64'(exp_log.size() != 0), 64'd1);
        if (exp_log.size() != 0) check("log_word", 64'(lfifo_data), 64'(exp_log.pop_front()));
      end
    end
  end

  task automatic push_res(input logic [23:0] res, input logic [4:0] cyc, input logic to);
    res_mem[res_wr % 64] = {res, cyc, to};
    res_wr++;
  endtask

  task automatic push_exp(input logic [23:0] mask, input logic [23:0] expv, input logic [4:0] ecyc);
    exp_mem[exp_wr % 64] = {mask, expv, ecyc};
    exp_wr++;
  endtask

  task automatic push_vec(input logic [23:0] res, input logic [4:0] cyc, input logic to,
                          input logic [23:0] mask, input logic [23:0] expv, input logic [4:0] ecyc,
                          input bit log_exp, input logic [15:0] idx);
    push_res(res, cyc, to);
    push_exp(mask, expv, ecyc);
    if (log_exp) exp_log.push_back({idx, res, cyc, to});
  endtask

  task automatic start_run(input logic [IDX_WIDTH-1:0] n);
    @(negedge clock);
    start       = 1'b1;
    num_vectors = n;
    @(negedge clock);
    start       = 1'b0;
  endtask

  task automatic wait_done(input string name, output int cycles);
    cycles = 0;
    while (!done && cycles < 300) begin
      @(negedge clock);
      cycles++;
    end
    check({name, "_done"}, 64'(done), 64'd1);
    @(negedge clock);
  endtask

  task automatic check_stats(input string name, input int p, input int f);
    check({name, "_pass"}, 64'(pass_count), 64'(p));
    check({name, "_fail"}, 64'(fail_count), 64'(f));
  endtask

  int cyc, rd0, wr0;
  bit cyc_fail;

  initial begin
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_counts", 64'({pass_count, fail_count}), 64'd0);
    check("rst_strobes", 64'({rfifo_rdreq, efifo_rdreq, lfifo_wrreq}), 64'd0);
    check("rst_log_data", 64'(lfifo_data), 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // 1: four matching vectors, full mask; 2 cycles each plus FETCH->DONE.
    for (int i = 0; i < 4; i++)
      push_vec(24'h111111 * (i + 1), 5'(i), 1'b0, 24'hFFFFFF, 24'h111111 * (i + 1), 5'(i), 1'b0, 16'd0);
    wr0 = wr_count;
    start_run(4);
    wait_done("t1", cyc);
    check("t1_latency", 64'(cyc), 64'd9);
    check_stats("t1", 4, 0);
    check("t1_busy", 64'(busy), 64'd0);
    check("t1_no_log", 64'(wr_count - wr0), 64'd0);

    // 2: masked low nibble passes; full mask fails and logs index 0.
    push_vec(24'h00000F, 5'd2, 1'b0, 24'hFFFFF0, 24'h000000, 5'd2, 1'b0, 16'd0);
    start_run(1);
    wait_done("t2a", cyc);
    check_stats("t2a", 1, 0);
    push_vec(24'h00000F, 5'd2, 1'b0, 24'hFFFFFF, 24'h000000, 5'd2, 1'b1, 16'd0);
    wr0 = wr_count;
    start_run(1);
    wait_done("t2b", cyc);
    check_stats("t2b", 0, 1);
    check("t2b_log_count", 64'(wr_count - wr0), 64'd1);

    // 3: timeout with matching data fails and logs the timeout bit.
    push_vec(24'hABCDEF, 5'd7, 1'b1, 24'hFFFFFF, 24'hABCDEF, 5'd7, 1'b1, 16'd0);
    start_run(1);
    wait_done("t3", cyc);
    check_stats("t3", 0, 1);

    // 4: LOG_FIFO full for 10 cycles: hold in LOG, no further reads, one write afterwards.
    lfifo_wrfull = 1'b1;
    push_vec(24'h000001, 5'd1, 1'b0, 24'hFFFFFF, 24'h000000, 5'd1, 1'b1, 16'd0);
    push_vec(24'h123456, 5'd3, 1'b0, 24'hFFFFFF, 24'h123456, 5'd3, 1'b0, 16'd0);
    rd0 = rd_count;
    wr0 = wr_count;
    start_run(2);
    repeat (10) @(negedge clock);
    check("t4_hold_busy", 64'(busy), 64'd1);
    check("t4_hold_reads", 64'(rd_count - rd0), 64'd1);
    check("t4_hold_writes", 64'(wr_count - wr0), 64'd0);
    lfifo_wrfull = 1'b0;
    wait_done("t4", cyc);
    check_stats("t4", 1, 1);
    check("t4_reads", 64'(rd_count - rd0), 64'd2);
    check("t4_writes", 64'(wr_count - wr0), 64'd1);

    // 5: EXP_FIFO empty stalls the read until it fills.
    rd0 = rd_count;
    push_res(24'h0F0F0F, 5'd4, 1'b0);
    start_run(1);
    repeat (6) @(negedge clock);
    check("t5_stall_reads", 64'(rd_count - rd0), 64'd0);
    check("t5_stall_busy", 64'(busy), 64'd1);
    push_exp(24'hFFFFFF, 24'h0F0F0F, 5'd4);
    wait_done("t5", cyc);
    check("t5_reads", 64'(rd_count - rd0), 64'd1);
    check_stats("t5", 1, 0);

    // 6: cycle 5 against exp_cycle 3 with matching data.
`ifdef RESCHK_CYCLE_CMP_EN
    cyc_fail = 1'b1;
`else
    cyc_fail = 1'b0;
`endif
    push_vec(24'h5A5A5A, 5'd5, 1'b0, 24'hFFFFFF, 24'h5A5A5A, 5'd3, cyc_fail, 16'd0);
    start_run(1);
    wait_done("t6", cyc);
    check_stats("t6", cyc_fail ? 0 : 1, cyc_fail ? 1 : 0);

    // 7: zero-length run: done two cycles after start, no reads, counters cleared.
    rd0 = rd_count;
    start_run(0);
    check("t7_not_yet_done", 64'(done), 64'd0);
    @(negedge clock);
    check("t7_done", 64'(done), 64'd1);
    check("t7_reads", 64'(rd_count - rd0), 64'd0);
    check_stats("t7", 0, 0);

    // 8: reset while parked in LOG clears every output.
    lfifo_wrfull = 1'b1;
    push_vec(24'hFFFFFF, 5'd0, 1'b0, 24'hFFFFFF, 24'h000000, 5'd0, 1'b0, 16'd0);
    wr0 = wr_count;
    start_run(1);
    repeat (4) @(negedge clock);
    check("t8_in_log_fail", 64'(fail_count), 64'd1);
    reset_n = 1'b0;
    #1;
    check("t8_busy", 64'(busy), 64'd0);
    check("t8_done", 64'(done), 64'd0);
    check("t8_counts", 64'({pass_count, fail_count}), 64'd0);
    check("t8_strobes", 64'({rfifo_rdreq, efifo_rdreq, lfifo_wrreq}), 64'd0);
    check("t8_log_data", 64'(lfifo_data), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    lfifo_wrfull = 1'b0;
    repeat (3) @(negedge clock);
    check("t8_idle", 64'({busy, done}), 64'd0);
    check("t8_no_write", 64'(wr_count - wr0), 64'd0);

    check("log_queue_drained", 64'(exp_log.size()), 64'd0);
    check("res_fifo_drained", 64'(res_wr - res_rd), 64'd0);
    check("exp_fifo_drained", 64'(exp_wr - exp_rd), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
